// File: rtl/cpu_dbg_pkg.sv
// Shared types and helpers for the CPU debug monitor: halt/step FSM states,
// the beat-decode error code, and a saturating counter increment.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_STEP   = 2'd2,
    ST_RESUME = 2'd3
  } dbg_state_e;

  // Beat index reported for zero or multi-hot beat vectors at the default BEAT_W of 5.
  localparam logic [3:0] BEAT_ERR = 4'd5;

  // Saturating increment; max_v is the counter's all-ones value at its real width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_dbg_monitor_trace.sv
// PC trace ring buffer: captures one word per write strobe and reads back
// combinationally by age (index 0 = most recent). Only built with DBG_TRACE_EN.
module dbg_trace_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_cpu,
  input  logic                     rst_cpu,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [DATA_W-1:0]        o_rd_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  r_wp;
  logic [IDX_W-1:0]  w_rd_ptr;

  // Entries are cleared on reset so slots not yet written read back as zero.
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      r_wp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[r_wp] <= i_wr_data;
      r_wp        <= r_wp + IDX_W'(1);
    end
  end

  // DEPTH is a power of two, so pointer arithmetic wraps modulo DEPTH for free.
  assign w_rd_ptr  = r_wp - IDX_W'(1) - i_rd_idx;
  assign o_rd_data = r_mem[w_rd_ptr];

endmodule

// File: rtl/cpu_dbg_monitor.sv
// Debug monitor for the multicycle CPU: display select, beat decode, saturating
// counters and a PC-breakpoint halt/step FSM. Optional PC trace via DBG_TRACE_EN.
module cpu_dbg_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = 16,
  parameter int BEAT_W      = 5,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clk_cpu,
  input  logic                           rst_cpu,
  input  logic [NUM_CH*DATA_W-1:0]       ch_data,
  input  logic [$clog2(NUM_CH)-1:0]      sel,
  input  logic [BEAT_W-1:0]              beat,
  input  logic                           ir_write,
  input  logic [DATA_W-1:0]              pc,
  input  logic [DATA_W-1:0]              bp_addr,
  input  logic                           bp_en,
  input  logic                           run_req,
  input  logic                           step,
  output logic                           halt,
  output logic [1:0]                     state_o,
  output logic [DATA_W-1:0]              disp_num,
  output logic [3:0]                     beat_idx,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic [CNT_W-1:0]               instr_cnt,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [DATA_W-1:0]              trace_pc
);

  localparam int             SEL_W     = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] W_CNT_MAX = '1;
  localparam logic [3:0]     W_BEAT_ERR = 4'(BEAT_W);

  dbg_state_e        r_state;
  logic              r_halt;
  logic [DATA_W-1:0] r_disp;
  logic [3:0]        r_beat_idx;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_instr_cnt;

  logic [DATA_W-1:0] w_sel_data;
  logic [3:0]        w_beat_pos;
  logic [4:0]        w_beat_hits;
  logic              w_bp_hit;
  logic              w_fetch_counted;

  // Out-of-range selects (possible when NUM_CH is not a power of two) show zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) w_sel_data = ch_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_beat_pos  = '0;
    w_beat_hits = '0;
    for (int i = 0; i < BEAT_W; i++) begin
      if (beat[i]) begin
        w_beat_hits = w_beat_hits + 5'd1;
        w_beat_pos  = 4'(i);
      end
    end
  end

  assign w_bp_hit        = bp_en & ir_write & (pc == bp_addr);
  assign w_fetch_counted = ir_write & ~r_halt;

  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      r_disp      <= '0;
      r_beat_idx  <= '0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_disp     <= w_sel_data;
      r_beat_idx <= (w_beat_hits == 5'd1) ? w_beat_pos : W_BEAT_ERR;
      if (!r_halt) begin
        r_cycle_cnt <= CNT_W'(sat_inc(32'(r_cycle_cnt), 32'(W_CNT_MAX)));
      end
      if (w_fetch_counted) begin
        r_instr_cnt <= CNT_W'(sat_inc(32'(r_instr_cnt), 32'(W_CNT_MAX)));
      end
    end
  end

  // Halt/step FSM. While halted the CPU is gated, so ir_write is meaningless there;
  // RESUME skips the compare once so the breakpoint PC does not re-trigger at once.
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      r_state <= ST_RUN;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_bp_hit) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (run_req) begin
            r_state <= step ? ST_STEP : ST_RESUME;
            r_halt  <= 1'b0;
          end
        end
        ST_STEP: begin
          if (ir_write) begin
            r_state <= ST_HALT;
            r_halt  <= 1'b1;
          end
        end
        ST_RESUME: begin
          if (ir_write) r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  assign halt      = r_halt;
  assign state_o   = r_state;
  assign disp_num  = r_disp;
  assign beat_idx  = r_beat_idx;
  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;

`ifdef DBG_TRACE_EN
  dbg_trace_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk_cpu   (clk_cpu),
    .rst_cpu   (rst_cpu),
    .i_wr_en   (w_fetch_counted),
    .i_wr_data (pc),
    .i_rd_idx  (trace_idx),
    .o_rd_data (trace_pc)
  );
`else
  logic w_trace_unused;
  assign w_trace_unused = ^trace_idx;
  assign trace_pc       = '0;
`endif

endmodule

// File: tb/tb_cpu_dbg_monitor.sv
// Self-checking bench for cpu_dbg_monitor: vector table for display/beat decode,
// hand sequences for breakpoint/step/resume/reset, and a randomized run vs a model.
module tb_cpu_dbg_monitor;
  import cpu_dbg_pkg::*;

  localparam int DATA_W      = 32;
  localparam int NUM_CH      = 8;
  localparam int CNT_W       = 16;
  localparam int BEAT_W      = 5;
  localparam int TRACE_DEPTH = 8;
  localparam int S_CH        = 6;
  localparam int S_CNT_W     = 4;

  logic clk_cpu = 1'b0;
  logic rst_cpu = 1'b1;
  always #5 clk_cpu = ~clk_cpu;

  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [2:0]               sel;
  logic [BEAT_W-1:0]        beat;
  logic                     ir_write, run_req, step, bp_en;
  logic [DATA_W-1:0]        pc, bp_addr;
  logic [2:0]               trace_idx;
  logic                     halt;
  logic [1:0]               state_o;
  logic [DATA_W-1:0]        disp_num, trace_pc;
  logic [3:0]               beat_idx;
  logic [CNT_W-1:0]         cycle_cnt, instr_cnt;

  logic [S_CH*DATA_W-1:0]   s_ch_data;
  logic [2:0]               s_sel;
  logic                     s_zero = 1'b0;
  logic                     s_halt;
  logic [1:0]               s_state;
  logic [DATA_W-1:0]        s_disp, s_trace_pc;
  logic [3:0]               s_beat_idx;
  logic [S_CNT_W-1:0]       s_cycle_cnt, s_instr_cnt;

  cpu_dbg_monitor #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BEAT_W(BEAT_W),
                    .TRACE_DEPTH(TRACE_DEPTH)) u_dut (
    .clk_cpu(clk_cpu), .rst_cpu(rst_cpu), .ch_data(ch_data), .sel(sel), .beat(beat),
    .ir_write(ir_write), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .run_req(run_req),
    .step(step), .halt(halt), .state_o(state_o), .disp_num(disp_num), .beat_idx(beat_idx),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .trace_idx(trace_idx), .trace_pc(trace_pc));

  cpu_dbg_monitor #(.DATA_W(DATA_W), .NUM_CH(S_CH), .CNT_W(S_CNT_W), .BEAT_W(BEAT_W),
                    .TRACE_DEPTH(TRACE_DEPTH)) u_small (
    .clk_cpu(clk_cpu), .rst_cpu(rst_cpu), .ch_data(s_ch_data), .sel(s_sel), .beat(beat),
    .ir_write(ir_write), .pc(pc), .bp_addr(bp_addr), .bp_en(s_zero), .run_req(s_zero),
    .step(s_zero), .halt(s_halt), .state_o(s_state), .disp_num(s_disp), .beat_idx(s_beat_idx),
    .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt), .trace_idx(trace_idx),
    .trace_pc(s_trace_pc));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ch_words [NUM_CH];
  bit                m_halted, m_step_armed, m_skip_bp;
  int                m_cyc, m_instr, m_s_cyc, m_beat;
  logic [DATA_W-1:0] m_disp;
  logic [DATA_W-1:0] m_trace [$];

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_halted = 0; m_step_armed = 0; m_skip_bp = 0;
    m_cyc = 0; m_instr = 0; m_s_cyc = 0; m_beat = 0; m_disp = '0;
    m_trace.delete();
  endfunction

  function automatic int exp_state();
    if (m_halted) return 1;
    if (m_step_armed) return 2;
    if (m_skip_bp) return 3;
    return 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_trace(input int idx);
    if (idx < m_trace.size()) return m_trace[m_trace.size()-1-idx];
    return '0;
  endfunction

  // Called just after each active edge; inputs are still the values seen by that edge.
  function automatic void model_edge();
    m_disp = ch_words[sel];
    m_beat = ($countones(beat) == 1) ? $clog2(beat) : BEAT_W;
    m_s_cyc = min_i(m_s_cyc + 1, (1 << S_CNT_W) - 1);
    if (m_halted) begin
      if (run_req) begin
        m_halted = 0; m_step_armed = step; m_skip_bp = !step;
      end
    end else begin
      m_cyc = min_i(m_cyc + 1, (1 << CNT_W) - 1);
      if (ir_write) begin
        m_instr = min_i(m_instr + 1, (1 << CNT_W) - 1);
        m_trace.push_back(pc);
        if (m_trace.size() > 64) void'(m_trace.pop_front());
        if (m_step_armed) begin m_halted = 1; m_step_armed = 0; end
        else if (m_skip_bp) m_skip_bp = 0;
        else if (bp_en && pc == bp_addr) m_halted = 1;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic ir, input logic [31:0] p, input logic rr, input logic st);
    ir_write = ir; pc = p; run_req = rr; step = st;
    @(posedge clk_cpu);
    model_edge();
    @(negedge clk_cpu);
    ir_write = 1'b0; run_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_cpu = 1'b1;
    model_reset();
    @(negedge clk_cpu);
    rst_cpu = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  beat;
    logic [31:0] exp_disp;
    logic [3:0]  exp_beat;
  } vec_t;
  vec_t vecs [8];

  initial begin
    for (int k = 0; k < NUM_CH; k++) ch_words[k] = 32'hC0DE_0000 + k;
    ch_words[3] = 32'hDEAD_BEEF;
    for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = ch_words[k];
    for (int k = 0; k < S_CH; k++) s_ch_data[k*DATA_W +: DATA_W] = 32'h5000_0000 + k;
    sel = 3'd0; s_sel = 3'd5; beat = 5'b00001; ir_write = 0; run_req = 0; step = 0;
    bp_en = 0; pc = '0; bp_addr = '0; trace_idx = '0;
    vecs[0] = '{3'd3, 5'b00001, 32'hDEAD_BEEF, 4'd0};
    vecs[1] = '{3'd0, 5'b00010, 32'hC0DE_0000, 4'd1};
    vecs[2] = '{3'd7, 5'b00100, 32'hC0DE_0007, 4'd2};
    vecs[3] = '{3'd1, 5'b01000, 32'hC0DE_0001, 4'd3};
    vecs[4] = '{3'd5, 5'b10000, 32'hC0DE_0005, 4'd4};
    vecs[5] = '{3'd3, 5'b00110, 32'hDEAD_BEEF, BEAT_ERR};
    vecs[6] = '{3'd2, 5'b00000, 32'hC0DE_0002, BEAT_ERR};
    vecs[7] = '{3'd6, 5'b11111, 32'hC0DE_0006, BEAT_ERR};

    // Reset values while reset is held
    #3;
    chk("rst_halt", 32'(halt), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_disp", disp_num, 0);
    chk("rst_beat", 32'(beat_idx), 0);
    chk("rst_cycle", 32'(cycle_cnt), 0);
    chk("rst_instr", 32'(instr_cnt), 0);
    chk("rst_trace", trace_pc, 0);
    do_reset();

    // Display latency: zero before the edge, selected channel after
    sel = 3'd3;
    #1 chk("disp_pre_edge", disp_num, 0);
    cyc(0, 0, 0, 0);
    chk("disp_ch3", disp_num, 32'hDEAD_BEEF);

    // Table: display select and beat decode
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel; beat = vecs[i].beat;
      cyc(0, 0, 0, 0);
      chk($sformatf("vec%0d_disp", i), disp_num, vecs[i].exp_disp);
      chk($sformatf("vec%0d_beat", i), 32'(beat_idx), 32'(vecs[i].exp_beat));
    end

    // Small instance: out-of-range select and 4-bit counter saturation
    chk("small_disp_ch5", s_disp, 32'h5000_0005);
    s_sel = 3'd6;
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    chk("small_disp_oob", s_disp, 0);
    chk("small_cycle_sat", 32'(s_cycle_cnt), 32'hF);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("small_cycle_hold", 32'(s_cycle_cnt), 32'hF);

    // Breakpoint / step / resume sequence
    do_reset();
    bp_en = 1; bp_addr = 32'h0C;
    cyc(1, 32'h00, 0, 0); cyc(1, 32'h04, 0, 0); cyc(1, 32'h08, 0, 0);
    chk("bp_not_yet", 32'(halt), 0);
    cyc(1, 32'h0C, 0, 0);
    chk("bp_halt", 32'(halt), 1);
    chk("bp_state", 32'(state_o), 1);
    chk("bp_instr", 32'(instr_cnt), 4);
    chk("bp_cycle", 32'(cycle_cnt), 4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("halt_cycle_frozen", 32'(cycle_cnt), 4);
    cyc(1, 32'h0C, 0, 0);
    chk("halt_no_runreq", 32'(state_o), 1);
    chk("halt_instr_frozen", 32'(instr_cnt), 4);
    cyc(1, 32'h20, 1, 1);
    chk("step_entered", 32'(state_o), 2);
    chk("step_halt_low", 32'(halt), 0);
    chk("step_ir_ignored", 32'(instr_cnt), 4);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("step_waiting", 32'(halt), 0);
    chk("step_cycle", 32'(cycle_cnt), 6);
    cyc(1, 32'h10, 0, 0);
    chk("step_rehalt", 32'(halt), 1);
    chk("step_instr", 32'(instr_cnt), 5);
    cyc(0, 0, 1, 0);
    chk("resume_state", 32'(state_o), 3);
    cyc(1, 32'h0C, 0, 0);
    chk("resume_skip_bp", 32'(halt), 0);
    chk("resume_to_run", 32'(state_o), 0);
    chk("resume_instr", 32'(instr_cnt), 6);
    cyc(0, 0, 1, 1);
    chk("runreq_in_run", 32'(state_o), 0);
    cyc(1, 32'h0C, 0, 0);
    chk("second_hit_halt", 32'(halt), 1);
    chk("second_hit_instr", 32'(instr_cnt), 7);
    chk("second_hit_cycle", 32'(cycle_cnt), 10);
    cyc(0, 0, 1, 1);
    chk("step_again", 32'(state_o), 2);

    // Asynchronous reset mid-STEP
    #2 rst_cpu = 1'b1;
    #1;
    chk("arst_halt", 32'(halt), 0);
    chk("arst_state", 32'(state_o), 0);
    chk("arst_cycle", 32'(cycle_cnt), 0);
    chk("arst_instr", 32'(instr_cnt), 0);
    do_reset();

    // Trace buffer readback
    bp_en = 0;
    cyc(1, 32'h00, 0, 0); cyc(1, 32'h04, 0, 0); cyc(1, 32'h08, 0, 0);
`ifdef DBG_TRACE_EN
    trace_idx = 3'd0; #1 chk("trace_idx0", trace_pc, 32'h08);
    trace_idx = 3'd1; #1 chk("trace_idx1", trace_pc, 32'h04);
    trace_idx = 3'd2; #1 chk("trace_idx2", trace_pc, 32'h00);
    trace_idx = 3'd3; #1 chk("trace_idx3", trace_pc, 32'h00);
`else
    trace_idx = 3'd0; #1 chk("trace_off0", trace_pc, 32'h00);
    trace_idx = 3'd2; #1 chk("trace_off2", trace_pc, 32'h00);
`endif

    // Randomized run against the reference model
    @(negedge clk_cpu);
    do_reset();
    bp_addr = 32'h0C;
    for (int n = 0; n < 600; n++) begin
      if ((n % 50) == 0) bp_addr = 32'(4 * $urandom_range(0, 5));
      bp_en     = ($urandom_range(0, 3) != 0);
      sel       = 3'($urandom_range(0, 7));
      beat      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'(1 << $urandom_range(0, 4));
      trace_idx = 3'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 5)),
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
      chk("rnd_halt", 32'(halt), 32'(m_halted));
      chk("rnd_state", 32'(state_o), 32'(exp_state()));
      chk("rnd_cycle", 32'(cycle_cnt), 32'(m_cyc));
      chk("rnd_instr", 32'(instr_cnt), 32'(m_instr));
      chk("rnd_disp", disp_num, m_disp);
      chk("rnd_beat", 32'(beat_idx), 32'(m_beat));
      chk("rnd_small_cycle", 32'(s_cycle_cnt), 32'(m_s_cyc));
`ifdef DBG_TRACE_EN
      chk("rnd_trace", trace_pc, exp_trace(int'(trace_idx)));
`else
      chk("rnd_trace_off", trace_pc, 32'h0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
